// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    // Sequencer states for a bit-serial operation.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width: it must hold the value WIDTH itself, because the
    // counter steps once more on the final bit and does not wrap.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with a borrow out.
// This is the mirror of the full-adder cell.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out. A borrow is needed when a < b, or when
    // a == b and a borrow is already pending.
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, D = A - B - bin, processed LSB first with
// one full-subtractor cell and a registered borrow. Operands arrive through
// a start handshake. The result leaves through a valid/ready handshake, and
// each difference bit is also streamed out while it is produced.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic [WIDTH-1:0] diff_out,
    output logic             bout,
    output logic             ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             ser_d,
    output logic             ser_valid
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // The register holds WIDTH-1 bits. The newest bit comes straight from the
    // cell, so the full result is {cell_d, res_sh} on the last bit.
    logic [WIDTH-2:0] res_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] res_next;

    full_subtractor_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Result register contents after the current bit is shifted in.
    assign res_next = {cell_d, res_sh};

    // Serial tap: the difference bit is presented only while bits are being
    // produced, and is forced to 0 otherwise.
    assign ser_valid = (state == RUN);
    assign ser_d     = ser_valid & cell_d;

    // Sequencer, datapath shift registers and registered handshake/result outputs.
    // NOTE: every assignment in this clocked block is non-blocking, so each
    // register reads values from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            diff_out    <= '0;
            bout        <= 1'b0;
            ovf         <= 1'b0;
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            borrow      <= 1'b0;
            cnt         <= '0;
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        a_sh        <= a_in;
                        b_sh        <= b_in;
                        borrow      <= bin;
                        a_msb       <= a_in[WIDTH-1];
                        b_msb       <= b_in[WIDTH-1];
                        res_sh      <= '0;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end

                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next[WIDTH-1:1];
                    borrow <= cell_bout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        diff_out  <= res_next;
                        bout      <= cell_bout;
                        // Signed overflow is only possible when the operand
                        // signs differ, and is flagged when the result sign
                        // does not match the minuend.
                        ovf       <= (a_msb != b_msb) && (cell_d != a_msb);
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin;
    logic [W-1:0] diff_out;
    logic         bout;
    logic         ovf;
    logic         res_valid;
    logic         res_ready;
    logic         busy;
    logic         ser_d;
    logic         ser_valid;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .bin         (bin),
        .diff_out    (diff_out),
        .bout        (bout),
        .ovf         (ovf),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .ser_d       (ser_d),
        .ser_valid   (ser_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: a 9-bit unsigned subtraction. Returns {ovf, bout, diff}.
    function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [8:0] r;
        logic       o;
        r = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        o = (a[7] != b[7]) && (r[7] != a[7]);
        return {o, r[8], r[7:0]};
    endfunction

    // Starts from a negedge in IDLE with res_ready=0. Runs one operation,
    // checks the serial stream and the captured result, and leaves the DUT in DONE.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] exp_d, input logic exp_b, input logic exp_o);
        check({tag, "_start_ready"}, start_ready, 1);
        start_valid = 1'b1;
        a_in = a;
        b_in = b;
        bin  = bi;
        @(negedge clk);
        start_valid = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        bin  = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready_low"}, start_ready, 0);
        for (int k = 0; k < W; k++) begin
            check({tag, "_ser_valid"}, ser_valid, 1);
            check({tag, "_ser_d"}, ser_d, exp_d[k]);
            check({tag, "_early_valid"}, res_valid, 0);
            @(negedge clk);
        end
        check({tag, "_res_valid"}, res_valid, 1);
        check({tag, "_diff"}, diff_out, exp_d);
        check({tag, "_bout"}, bout, exp_b);
        check({tag, "_ovf"}, ovf, exp_o);
        check({tag, "_ser_idle"}, {ser_valid, ser_d}, 0);
    endtask

    // Pulses res_ready for one edge and checks the return to IDLE, with the result retained.
    task automatic release_result(input string tag, input logic [7:0] exp_d);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, res_valid, 0);
        check({tag, "_ready_back"}, start_ready, 1);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_retained"}, diff_out, exp_d);
    endtask

    initial begin
        logic [9:0] exp;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbi;
        int         seen_valid;

        rst_n       = 1'b0;
        start_valid = 1'b0;
        a_in        = 8'h00;
        b_in        = 8'h00;
        bin         = 1'b0;
        res_ready   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_start_ready", start_ready, 1);
        check("rst_outputs", {diff_out, bout, ovf}, 0);
        check("rst_flags", {res_valid, busy, ser_d, ser_valid}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic subtractions, boundary values and borrow-in.
        do_op("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        release_result("t1", 8'h02);
        do_op("t2", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        release_result("t2", 8'hFE);
        do_op("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        release_result("t3a", 8'h7F);
        do_op("t3b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        release_result("t3b", 8'hFF);
        do_op("bin1", 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0);
        release_result("bin1", 8'h0E);
        do_op("neg_ovf", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        release_result("neg_ovf", 8'h80);

        // Backpressure: hold the result and ignore start pulses while DONE.
        do_op("bp", 8'hC3, 8'h41, 1'b0, 8'h82, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start_valid = i[0];
            a_in = 8'h11;
            b_in = 8'h22;
            @(negedge clk);
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_diff", diff_out, 8'h82);
            check("bp_hold_flags", {bout, ovf}, 0);
            check("bp_no_start", start_ready, 0);
        end
        start_valid = 1'b0;
        release_result("bp", 8'h82);

        // Reset mid-operation at counter value 3.
        start_valid = 1'b1;
        a_in = 8'h12;
        b_in = 8'h34;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_ser_valid", ser_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {diff_out, bout, ovf}, 0);
        check("mid_rst_flags", {res_valid, busy, ser_valid, ser_d}, 0);
        check("mid_rst_ready", start_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen_valid++;
        end
        check("mid_rst_never_valid", seen_valid, 0);
        do_op("post_rst", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);
        release_result("post_rst", 8'h55);

        // Back-to-back: start_valid and res_ready held high; one accept per W+2 cycles.
        res_ready   = 1'b1;
        start_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom);
            exp = ref_sub(ra, rb, rbi);
            check("b2b_ready", start_ready, 1);
            a_in = ra;
            b_in = rb;
            bin  = rbi;
            @(negedge clk);
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            bin  = 1'($urandom);
            repeat (W) @(negedge clk);
            check("b2b_valid", res_valid, 1);
            check("b2b_diff", diff_out, exp[7:0]);
            check("b2b_bout_ovf", {ovf, bout}, exp[9:8]);
            @(negedge clk);
        end
        start_valid = 1'b0;
        res_ready   = 1'b0;
        @(negedge clk);
        check("b2b_idle", {start_ready, busy, res_valid}, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes D = A − B − bin, LSB first, one bit per clock, using a single 1-bit full-subtractor cell and a registered borrow.
- It is the inverse-direction companion to the team's 1-bit full-adder cell.
- It sits between a host register interface (start handshake) and a result consumer (valid/ready handshake).
- It also streams each difference bit out as it is produced.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  host presents operands.
- start_ready  output  1  block can accept operands.
- a_in  input  WIDTH  minuend A.
- b_in  input  WIDTH  subtrahend B.
- bin  input  1  borrow-in, sampled with the operands.
- diff_out  output  WIDTH  difference D.
- bout  output  1  final borrow-out; 1 means unsigned A < B + bin.
- ovf  output  1  signed two's-complement overflow.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- busy  output  1  high in RUN or DONE.
- ser_d  output  1  current serial difference bit.
- ser_valid  output  1  ser_d is valid this cycle.

Behaviour:
- Reset is asynchronous and active-low on rst_n; all state is clocked on the rising edge of clk.
- Reset values: state=IDLE, start_ready=1, diff_out=0, bout=0, ovf=0, res_valid=0, busy=0, ser_d=0, ser_valid=0, internal shift registers, borrow and bit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready, latch a_in, b_in and bin into the A shift register, B shift register and borrow flop; clear the counter; go to RUN.
  - Operands are ignored in every other state (start_ready=0).
- RUN, each cycle k = 0..WIDTH-1 (counter value):
  - a = A[0], b = B[0], r = borrow.
  - d = a ^ b ^ r.
  - borrow_next = (~a & b) | (~(a ^ b) & r).
  - ser_d = d combinationally, ser_valid = 1.
  - On the edge: shift A and B right by one; shift d into the MSB of the result register; borrow <= borrow_next; counter++.
  - When k = WIDTH-1, on that edge also capture the result:
    - diff_out <= {d, result[WIDTH-1:1]} (final value).
    - bout <= borrow_next.
    - ovf <= (A_orig[MSB] != B_orig[MSB]) && (d != A_orig[MSB]); the operand MSBs are kept in a dedicated flop pair.
    - res_valid <= 1; go to DONE.
- Latency: the accept edge is edge 0; res_valid is high after edge WIDTH (8 cycles for WIDTH=8). Throughput is one operation per WIDTH+2 cycles at minimum.
- DONE:
  - res_valid=1; diff_out, bout and ovf are held stable while res_valid=1 and res_ready=0.
  - On res_ready, res_valid <= 0 and the FSM goes to IDLE.
  - A new start is not accepted in the same cycle.
- diff_out, bout and ovf retain their last values after returning to IDLE, until the next result capture.
- ser_valid=0 outside RUN; ser_d=0 when ser_valid=0.
- Counter width is clog2(WIDTH)+1; there is no wrap-around within an operation.
- Reset asserted mid-RUN or mid-DONE: everything returns to reset values immediately; no partial result is ever flagged valid.
- start_valid asserted during RUN/DONE: no effect; the host must hold start_valid until it sees start_ready.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum type (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH constant;
  - a counter-width function.
- One natural sub-module: full_subtractor_cell, a combinational cell with inputs a, b, bin and outputs d, bout. It is instantiated once, and is the mirror of the existing adder cell.

Test Plan:
1. WIDTH=8, A=0x05, B=0x03, bin=0 -> after 8 cycles diff_out=0x02, bout=0, ovf=0; ser_d stream LSB-first = 0,1,0,0,0,0,0,0.
2. A=0x03, B=0x05, bin=0 -> diff_out=0xFE, bout=1, ovf=0.
3. A=0x80, B=0x01, bin=0 -> diff_out=0x7F, bout=0, ovf=1. Also A=0x00, B=0x00, bin=1 -> diff_out=0xFF, bout=1, ovf=0.
4. Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_valid and diff_out stable, start_ready=0, start_valid pulses ignored; raising res_ready -> res_valid drops next edge and start_ready=1.
5. Reset mid-operation: assert rst_n=0 at RUN counter=3 -> outputs immediately at reset values, res_valid never asserts; after release, a new A=0xAA, B=0x55 yields 0x55, bout=0, ovf=1.
6. Back-to-back: start_valid held high continuously with res_ready=1 -> accepts every WIDTH+2 cycles; randomised 1000-operand run checked against a reference model.
